// File: rtl/cam_capture_axis_if.sv
// AXI4-Stream pixel channel: 16-bit RGB565 data, frame-start on tuser, line-end on tlast.
interface cam_capture_axis_if;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/cam_capture_axis.sv
// DVP camera capture: byte pairs -> RGB565 pixels -> FIFO -> AXI4-Stream master.
// Optional CAM_CAPTURE_BYTESWAP_EN: pixel = {second byte, first byte}.
module cam_capture_axis #(
  parameter int unsigned FRAME_WIDTH  = 8,
  parameter int unsigned FRAME_HEIGHT = 4,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                pclk,
  input  logic                reset_n,
  input  logic                vsync,
  input  logic                href,
  input  logic [7:0]          data_in,
  cam_capture_axis_if.master  m_axis,
  output logic [7:0]          frame_count,
  output logic                overflow,
  output logic                size_err
);

  localparam int unsigned COL_W = $clog2(FRAME_WIDTH + 2);
  localparam int unsigned ROW_W = $clog2(FRAME_HEIGHT + 2);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FRAME_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_FULL = COL_W'(FRAME_WIDTH);
  localparam logic [COL_W-1:0] COL_SAT  = COL_W'(FRAME_WIDTH + 1);
  localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(FRAME_HEIGHT);
  localparam logic [ROW_W-1:0] ROW_SAT  = ROW_W'(FRAME_HEIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic        user;
    logic        last;
    logic [15:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    IN_SYNC,
    ACTIVE
  } state_t;

  state_t            state_q, state_d;
  logic              href_q, href_d;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [7:0]        frame_count_q, frame_count_d;
  logic              size_err_q, size_err_d;
  logic              overflow_q, overflow_d;
  logic              pix_valid_q, pix_valid_d;
  entry_t            pix_q, pix_d;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              tvalid_q, tvalid_d;
  entry_t            mem_q [FIFO_DEPTH];

  logic [ROW_W-1:0]  row_inc;
  logic              line_bad;
  logic              push;
  logic              pop;
  logic              full;
  entry_t            head;

  // Capture FSM, byte assembly and geometry checking.
  always_comb begin
    state_d       = state_q;
    href_d        = 1'b0;
    phase_d       = phase_q;
    hi_d          = hi_q;
    col_d         = col_q;
    row_d         = row_q;
    frame_count_d = frame_count_q;
    size_err_d    = size_err_q;
    pix_valid_d   = 1'b0;
    pix_d         = pix_q;
    row_inc       = (row_q == ROW_SAT) ? row_q : row_q + ROW_W'(1);
    line_bad      = phase_q || (col_q != COL_FULL);

    case (state_q)
      WAIT_SYNC: begin
        if (vsync) state_d = IN_SYNC;
      end

      IN_SYNC: begin
        row_d   = '0;
        col_d   = '0;
        phase_d = 1'b0;
        if (!vsync) state_d = ACTIVE;
      end

      ACTIVE: begin
        if (vsync) begin
          // A line still open at vsync is closed first, then the frame ends.
          state_d       = IN_SYNC;
          frame_count_d = frame_count_q + 8'd1;
          if (href_q) begin
            if (line_bad || (row_inc != ROW_FULL)) size_err_d = 1'b1;
          end else if (row_q != ROW_FULL) begin
            size_err_d = 1'b1;
          end
        end else if (href) begin
          href_d  = 1'b1;
          phase_d = !phase_q;
          if (!phase_q) begin
            hi_d = data_in;
          end else begin
            col_d = (col_q == COL_SAT) ? col_q : col_q + COL_W'(1);
            if ((col_q >= COL_FULL) || (row_q >= ROW_FULL)) begin
              size_err_d = 1'b1;
            end else begin
              pix_valid_d = 1'b1;
              pix_d.user  = (row_q == '0) && (col_q == '0);
              pix_d.last  = (col_q == COL_LAST);
`ifdef CAM_CAPTURE_BYTESWAP_EN
              pix_d.data  = {data_in, hi_q};
`else
              pix_d.data  = {hi_q, data_in};
`endif
            end
          end
        end else if (href_q) begin
          row_d   = row_inc;
          col_d   = '0;
          phase_d = 1'b0;
          if (line_bad) size_err_d = 1'b1;
        end
      end

      default: state_d = WAIT_SYNC;
    endcase
  end

  // Pixel FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
  always_comb begin
    pop        = tvalid_q && m_axis.tready;
    full       = (count_q == CNT_FULL);
    push       = pix_valid_q && (!full || pop);
    overflow_d = overflow_q || (pix_valid_q && full && !pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    tvalid_d = (count_d != '0);
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= WAIT_SYNC;
      href_q        <= 1'b0;
      phase_q       <= 1'b0;
      hi_q          <= '0;
      col_q         <= '0;
      row_q         <= '0;
      frame_count_q <= '0;
      size_err_q    <= 1'b0;
      overflow_q    <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      tvalid_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      href_q        <= href_d;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      col_q         <= col_d;
      row_q         <= row_d;
      frame_count_q <= frame_count_d;
      size_err_q    <= size_err_d;
      overflow_q    <= overflow_d;
      pix_valid_q   <= pix_valid_d;
      pix_q         <= pix_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      tvalid_q      <= tvalid_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge pclk) begin
    if (push) mem_q[wr_ptr_q] <= pix_q;
  end

  assign head          = mem_q[rd_ptr_q];
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tvalid_q ? head.data : '0;
  assign m_axis.tuser  = tvalid_q ? head.user : 1'b0;
  assign m_axis.tlast  = tvalid_q ? head.last : 1'b0;
  assign frame_count   = frame_count_q;
  assign overflow      = overflow_q;
  assign size_err      = size_err_q;

endmodule

// File: tb/tb_cam_capture_axis.sv
// Randomized self-checking bench for cam_capture_axis against a frame-level pixel model.
module tb_cam_capture_axis;
  localparam int W = 8;
  localparam int H = 4;
  localparam int DEPTH = 8;
`ifdef CAM_CAPTURE_BYTESWAP_EN
  localparam logic [15:0] PIX_R2C5 = 16'h0502;
  localparam logic [15:0] PIX_R2C0 = 16'h0002;
`else
  localparam logic [15:0] PIX_R2C5 = 16'h0205;
  localparam logic [15:0] PIX_R2C0 = 16'h0200;
`endif

  logic       pclk;
  logic       reset_n;
  logic       vsync;
  logic       href;
  logic [7:0] data_in;
  logic [7:0] frame_count;
  logic       overflow;
  logic       size_err;

  cam_capture_axis_if axis_if ();

  cam_capture_axis #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .FIFO_DEPTH(DEPTH)) dut (
    .pclk        (pclk),
    .reset_n     (reset_n),
    .vsync       (vsync),
    .href        (href),
    .data_in     (data_in),
    .m_axis      (axis_if),
    .frame_count (frame_count),
    .overflow    (overflow),
    .size_err    (size_err)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [17:0] got[$];
  logic [17:0] exp_q[$];
  int got_t[$];
  bit frame_open;
  int mrow;
  int mframes;
  bit merr;
  bit stall_q = 0;
  logic [17:0] stall_ent;

  always @(posedge pclk) cyc++;

  // Monitor just before each rising edge: record transfers, check stalled beats hold.
  always @(negedge pclk) begin
    #4;
    if (!reset_n) begin
      stall_q = 0;
    end else begin
      if (stall_q) begin
        checks++;
        if (!axis_if.tvalid || {axis_if.tuser, axis_if.tlast, axis_if.tdata} !== stall_ent) begin
          errors++;
          $display("FAIL axis_stable got v=%b %h exp v=1 %h", axis_if.tvalid,
                   {axis_if.tuser, axis_if.tlast, axis_if.tdata}, stall_ent);
        end
      end
      if (axis_if.tvalid && axis_if.tready) begin
        got.push_back({axis_if.tuser, axis_if.tlast, axis_if.tdata});
        got_t.push_back(cyc);
      end
      stall_q   = axis_if.tvalid && !axis_if.tready;
      stall_ent = {axis_if.tuser, axis_if.tlast, axis_if.tdata};
    end
  end

  task automatic drive(input logic vs, input logic hr, input logic [7:0] d, input logic rdy);
    @(negedge pclk);
    vsync = vs;
    href = hr;
    data_in = d;
    axis_if.tready = rdy;
  endtask

  task automatic clear_model();
    got.delete();
    got_t.delete();
    exp_q.delete();
    frame_open = 0;
    mrow = 0;
    mframes = 0;
    merr = 0;
  endtask

  task automatic apply_reset();
    drive(0, 0, 8'h00, 0);
    reset_n = 1'b0;
    repeat (3) drive(0, 0, 8'h00, 0);
    clear_model();
    reset_n = 1'b1;
    drive(0, 0, 8'h00, 0);
  endtask

  task automatic vsync_pulse(input logic rdy);
    if (frame_open) begin
      mframes++;
      if (mrow != H) merr = 1;
    end
    frame_open = 1;
    mrow = 0;
    repeat (3) drive(1, 0, 8'h00, rdy);
    repeat (4) drive(0, 0, 8'h00, rdy);
  endtask

  // mode 0: tready low, 1: tready high, 2: random tready during the line.
  task automatic send_line(input int nbytes, input int mode, input bit rnd, input bit keep);
    logic [7:0] b[$];
    logic [15:0] px;
    logic rdy;
    for (int i = 0; i < nbytes; i++)
      b.push_back(rnd ? 8'($urandom) : ((i % 2 == 0) ? 8'(mrow) : 8'(i / 2)));
    if (frame_open) begin
      for (int c = 0; c < nbytes / 2; c++) begin
`ifdef CAM_CAPTURE_BYTESWAP_EN
        px = {b[2*c+1], b[2*c]};
`else
        px = {b[2*c], b[2*c+1]};
`endif
        if (c < W && mrow < H) begin
          if (keep) exp_q.push_back({(c == 0 && mrow == 0), (c == W - 1), px});
        end else begin
          merr = 1;
        end
      end
      if (nbytes != 2 * W) merr = 1;
      mrow++;
    end
    for (int i = 0; i < nbytes; i++) begin
      rdy = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      drive(0, 1, b[i], rdy);
    end
    repeat (12) drive(0, 0, 8'h00, mode != 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) drive(0, 0, 8'h00, 1);
    checks++;
    if ({axis_if.tvalid, axis_if.tuser, axis_if.tlast, axis_if.tdata} !== 19'h0) begin
      errors++;
      $display("FAIL reset_axis got %h exp 0", {axis_if.tvalid, axis_if.tuser, axis_if.tlast, axis_if.tdata});
    end
    checks++;
    if ({frame_count, overflow, size_err} !== 10'h0) begin
      errors++;
      $display("FAIL reset_status got %h exp 0", {frame_count, overflow, size_err});
    end
    clear_model();
    reset_n = 1'b1;
    send_line(2 * W, 1, 1, 1);
    checks++;
    if (got.size() != 0 || size_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_nosync got n=%0d err=%b exp n=0 err=0", got.size(), size_err);
    end
  endtask

  task automatic test_nominal();
    int nu, nl;
    apply_reset();
    vsync_pulse(1);
    for (int r = 0; r < H; r++) send_line(2 * W, 1, 0, 1);
    vsync_pulse(1);
    checks++;
    if (got.size() != W * H || exp_q.size() != W * H) begin
      errors++;
      $display("FAIL nominal_count got %0d exp %0d", got.size(), W * H);
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL nominal_pix[%0d] got %h exp %h", i, got[i], exp_q[i]);
      end
    end
    checks++;
    if (got.size() <= 21 || got[21][15:0] !== PIX_R2C5) begin
      errors++;
      $display("FAIL nominal_r2c5 got %h exp %h", (got.size() > 21) ? got[21][15:0] : 16'hxxxx, PIX_R2C5);
    end
    nu = 0;
    nl = 0;
    foreach (got[i]) begin
      if (got[i][17]) nu++;
      if (got[i][16]) nl++;
    end
    checks++;
    if (nu != 1 || got.size() == 0 || got[0] !== 18'h20000) begin
      errors++;
      $display("FAIL nominal_tuser got n=%0d exp n=1 on pixel 0000", nu);
    end
    checks++;
    if (nl != H) begin
      errors++;
      $display("FAIL nominal_tlast got %0d exp %0d", nl, H);
    end
    checks++;
    if (frame_count !== 8'd1 || size_err !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL nominal_status got fc=%0d se=%b ov=%b exp fc=1 se=0 ov=0", frame_count, size_err, overflow);
    end
  endtask

  task automatic test_random_frames();
    got.delete();
    got_t.delete();
    exp_q.delete();
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < H; r++) send_line(2 * W, 2, 1, 1);
      vsync_pulse(1);
    end
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count got %0d exp %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_pix[%0d] got %h exp %h", i, got[i], exp_q[i]);
      end
    end
    checks++;
    if (frame_count !== 8'(mframes) || size_err !== merr || overflow !== 1'b0) begin
      errors++;
      $display("FAIL random_status got fc=%0d se=%b ov=%b exp fc=%0d se=%b ov=0",
               frame_count, size_err, overflow, mframes, merr);
    end
  endtask

  task automatic test_overflow_back_to_back();
    apply_reset();
    vsync_pulse(0);
    send_line(2 * W, 0, 1, 1);
    send_line(2 * W, 0, 1, 0);
    checks++;
    if (overflow !== 1'b1 || axis_if.tvalid !== 1'b1 || got.size() != 0) begin
      errors++;
      $display("FAIL ovf_stalled got ov=%b v=%b n=%0d exp ov=1 v=1 n=0", overflow, axis_if.tvalid, got.size());
    end
    repeat (12) drive(0, 0, 8'h00, 1);
    checks++;
    if (got.size() != DEPTH) begin
      errors++;
      $display("FAIL ovf_retained got %0d exp %0d", got.size(), DEPTH);
    end
    checks++;
    if (got_t.size() < DEPTH || got_t[DEPTH-1] - got_t[0] != DEPTH - 1) begin
      errors++;
      $display("FAIL back_to_back got span=%0d exp %0d", (got_t.size() >= DEPTH) ? got_t[DEPTH-1] - got_t[0] : -1, DEPTH - 1);
    end
    send_line(2 * W, 1, 1, 1);
    send_line(2 * W, 2, 1, 1);
    vsync_pulse(1);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ovf_count got %0d exp %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ovf_pix[%0d] got %h exp %h", i, got[i], exp_q[i]);
      end
    end
    checks++;
    if (overflow !== 1'b1 || size_err !== 1'b0 || frame_count !== 8'd1) begin
      errors++;
      $display("FAIL ovf_status got ov=%b se=%b fc=%0d exp ov=1 se=0 fc=1", overflow, size_err, frame_count);
    end
  endtask

  task automatic test_short_line();
    apply_reset();
    vsync_pulse(1);
    send_line(2 * W, 1, 0, 1);
    send_line(2 * W - 1, 1, 0, 1);
    send_line(2 * W, 1, 0, 1);
    send_line(2 * W, 1, 0, 1);
    vsync_pulse(1);
    checks++;
    if (got.size() != exp_q.size() || got.size() != 4 * W - 1) begin
      errors++;
      $display("FAIL short_count got %0d exp %0d", got.size(), 4 * W - 1);
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL short_pix[%0d] got %h exp %h", i, got[i], exp_q[i]);
      end
    end
    checks++;
    if (got.size() <= 15 || got[15] !== {2'b00, PIX_R2C0} || got[14][16] !== 1'b0) begin
      errors++;
      $display("FAIL short_nextline got %h exp %h", (got.size() > 15) ? got[15] : 18'hx, {2'b00, PIX_R2C0});
    end
    checks++;
    if (size_err !== 1'b1 || frame_count !== 8'd1) begin
      errors++;
      $display("FAIL short_status got se=%b fc=%0d exp se=1 fc=1", size_err, frame_count);
    end
  endtask

  task automatic test_three_lines();
    apply_reset();
    vsync_pulse(1);
    for (int r = 0; r < H - 1; r++) send_line(2 * W, 2, 1, 1);
    vsync_pulse(1);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL three_count got %0d exp %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL three_pix[%0d] got %h exp %h", i, got[i], exp_q[i]);
      end
    end
    checks++;
    if (size_err !== 1'b1 || frame_count !== 8'd1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL three_status got se=%b fc=%0d ov=%b exp se=1 fc=1 ov=0", size_err, frame_count, overflow);
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    vsync_pulse(0);
    send_line(2 * W, 0, 1, 0);
    for (int i = 0; i < 6; i++) drive(0, 1, 8'($urandom), 0);
    checks++;
    if (axis_if.tvalid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre got v=%b exp v=1", axis_if.tvalid);
    end
    @(negedge pclk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (axis_if.tvalid !== 1'b0 || axis_if.tlast !== 1'b0 || frame_count !== 8'd0) begin
      errors++;
      $display("FAIL midrst_async got v=%b l=%b fc=%0d exp 0 0 0", axis_if.tvalid, axis_if.tlast, frame_count);
    end
    clear_model();
    repeat (2) drive(0, 1, 8'($urandom), 1);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) drive(0, 1, 8'($urandom), 1);
    repeat (6) drive(0, 0, 8'h00, 1);
    send_line(2 * W, 1, 1, 1);
    checks++;
    if (got.size() != 0) begin
      errors++;
      $display("FAIL midrst_quiet got %0d exp 0", got.size());
    end
    vsync_pulse(1);
    for (int r = 0; r < H; r++) send_line(2 * W, 2, 1, 1);
    vsync_pulse(1);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midrst_count got %0d exp %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midrst_pix[%0d] got %h exp %h", i, got[i], exp_q[i]);
      end
    end
    checks++;
    if (got.size() == 0 || got[0][17] !== 1'b1 || frame_count !== 8'd1 || size_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_first got u=%b fc=%0d se=%b exp u=1 fc=1 se=0",
               (got.size() > 0) ? got[0][17] : 1'bx, frame_count, size_err);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    vsync = 1'b0;
    href = 1'b0;
    data_in = 8'h00;
    axis_if.tready = 1'b0;
    test_reset();
    test_nominal();
    test_random_frames();
    test_overflow_back_to_back();
    test_short_line();
    test_three_lines();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
